// File: rtl/nibble_serial_add_ctrl.sv
// Purpose : WIDTH-bit add (optionally subtract) on one shared external 4-bit adder, one nibble per clock, LSB first.
// Latency : start accepted in cycle T -> done pulses in cycle T+NIB+1; one operation every NIB+2 cycles.
// Backpres: start is honoured only while ready=1; requests in RUN/DONE are dropped, never queued.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   start, a, b, cin     request and operands, sampled when start && ready
//   sub                  (only when SUB_EN is defined) 1 = compute a-b, cin ignored
//   ready, busy, done    IDLE / RUN / one-cycle DONE indications (registered)
//   sum, cout            result registers, valid while done=1, held until the next RUN
//   add_a, add_b,        operand nibbles and carry driven to the external adder,
//   add_cin              all zero outside RUN
//   add_f, add_cout      combinational result returned by the external adder
//
// Build option: define SUB_EN to add the 'sub' port and subtract support.
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_f,
    input  logic             add_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic                  carry;
    // Operands and result held as nibble arrays so nibble k is a plain index.
    logic [NIB-1:0][3:0]   opa;
    logic [NIB-1:0][3:0]   opb;
    logic [NIB-1:0][3:0]   sum_q;

    assign sum = sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum_q <= '0;
            cout  <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa   <= a;
`ifdef SUB_EN
                        // a - b computed as a + ~b + 1; final carry is the no-borrow flag.
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        opb   <= b;
                        carry <= cin;
`endif
                        k     <= '0;
                        state <= S_RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[k] <= add_f;
                    carry    <= add_cout;
                    if (k == K_LAST) begin
                        cout  <= add_cout;
                        k     <= '0;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    k     <= '0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Adder inputs are forced to zero outside RUN so the shared adder sits still.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = opa[k];
            add_b   = opb[k];
            add_cin = carry;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Purpose : self-checking bench for nibble_serial_add_ctrl with an ideal 4-bit adder attached.
// Latency : reference model predicts done in cycle (accept cycle)+NIB+1 and checks every cycle.
// Backpres: model accepts a request only when it expects ready=1; other requests are dropped.

module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_f;
    logic             add_cout;

    always #5 clk = ~clk;

    // Ideal combinational 4-bit adder standing in for the external CLA.
    assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SUB_EN
        .sub      (sub),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_f    (add_f),
        .add_cout (add_cout)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             sb;
        int               acc;
    } op_t;

    op_t              pend[$];
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;
    bit               model_vld = 1'b0;
    int               checks    = 0;
    int               errors    = 0;
    int               cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model at the negedge, then drive new inputs.
    task automatic step(input logic st, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input logic sb, input logic rs);
        logic             exp_ready;
        logic             exp_busy;
        logic             exp_done;
        op_t              p;
        int               k;
        logic [WIDTH-1:0] binv;
        logic [31:0]      eb, lm, ecy, c0;
        logic [WIDTH:0]   res;
        logic             sb_eff;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        @(negedge clk);
        if (model_vld) begin
            exp_ready = (pend.size() == 0);
            if (!exp_ready) begin
                p        = pend[0];
                exp_done = (cyc == p.acc + NIB + 1);
                exp_busy = (cyc <  p.acc + NIB + 1);
            end
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("busy",  32'(busy),  32'(exp_busy));
            chk("done",  32'(done),  32'(exp_done));
            if (exp_busy) begin
                k    = cyc - p.acc - 1;
                binv = ~p.b;
                eb   = p.sb ? 32'(binv) : 32'(p.b);
                c0   = p.sb ? 32'd1 : 32'(p.ci);
                lm   = (32'd1 << (4 * k)) - 32'd1;
                ecy  = ((32'(p.a) & lm) + (eb & lm) + c0) >> (4 * k);
                chk("add_a",   32'(add_a),   (32'(p.a) >> (4 * k)) & 32'hF);
                chk("add_b",   32'(add_b),   (eb >> (4 * k)) & 32'hF);
                chk("add_cin", 32'(add_cin), ecy & 32'h1);
            end else begin
                if (exp_done) begin
                    if (p.sb) res = {(p.a >= p.b), p.a - p.b};
                    else      res = {1'b0, p.a} + {1'b0, p.b} + {{WIDTH{1'b0}}, p.ci};
                    last_sum  = res[WIDTH-1:0];
                    last_cout = res[WIDTH];
                    void'(pend.pop_front());
                end
                chk("sum",      32'(sum),     32'(last_sum));
                chk("cout",     32'(cout),    32'(last_cout));
                chk("idle_a",   32'(add_a),   32'd0);
                chk("idle_b",   32'(add_b),   32'd0);
                chk("idle_cin", 32'(add_cin), 32'd0);
            end
        end
`ifdef SUB_EN
        sub    = sb;
        sb_eff = sb;
`else
        sb_eff = 1'b0;
`endif
        start = st;
        a     = av;
        b     = bv;
        cin   = ci;
        rst_n = rs;
        if (!rs) begin
            pend.delete();
            last_sum  = '0;
            last_cout = 1'b0;
            model_vld = 1'b1;
        end else if (model_vld && st && exp_ready) begin
            pend.push_back('{av, bv, ci, sb_eff, cyc});
        end
    endtask

    task automatic idle_step();
        step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // Wait (bounded) until the model expects IDLE, then present one request.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb);
        int n;
        n = 0;
        while (pend.size() != 0 && n < 4 * NIB) begin
            idle_step();
            n++;
        end
        chk("issue_wait", 32'(pend.size()), 32'd0);
        step(1'b1, av, bv, ci, sb, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < NIB + 3; i++) idle_step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SUB_EN
        sub   = 1'b0;
`endif
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle_step();

        // Directed cases: plain sum, full carry ripple, carry-in only.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0); drain();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
        issue(16'h0000, 16'h0000, 1'b1, 1'b0); drain();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); drain();

        // start held high with operands changing every cycle.
        for (int i = 0; i < 4 * (NIB + 2); i++)
            step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'b1);
        drain();

        // Reset asserted during the second RUN cycle aborts the operation.
        issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
        idle_step();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        idle_step();
        drain();

`ifdef SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1); drain();
        issue(16'h0007, 16'h0005, 1'b1, 1'b1); drain();
        issue(16'h1234, 16'h1234, 1'b0, 1'b1); drain();
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            step(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) != 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
